// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 5;
   localparam int unsigned CNT_W     = $clog2(DIV_WIDTH + 1);

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StCalc = 2'd1;
   localparam state_t StDone = 2'd2;

endpackage

// File: rtl/trial_subtractor.sv
// Combinational ripple-borrow subtractor: diff_o = a_i - b_i, borrow_out_o set when a_i < b_i.
module trial_subtractor
   import div_pkg::*;
#(
   parameter int unsigned W = DIV_WIDTH + 1
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_out_o
);

   logic [W:0] borrow;

   assign borrow[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_stage
      assign diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow[i];
      assign borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
   end

   assign borrow_out_o = borrow[W];

endmodule

// File: rtl/seq_divider_5bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN to add two's-complement operation (signed_in / overflow ports).
module seq_divider_5bit
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SIGNED_DIV_EN
   input  logic             signed_in,
   output logic             overflow,
`endif
   input  logic             start_in,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   state_t            state_q, state_d;
   logic [WIDTH:0]    p_q, p_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  dvs_q, dvs_d;
   logic [WIDTH-1:0]  dvd_q, dvd_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  quo_q, quo_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              dbz_q, dbz_d;

   logic [WIDTH:0]    p_sh;
   logic [WIDTH:0]    diff;
   logic              borrow;
   logic              take;
   logic [WIDTH-1:0]  dvd_mag;
   logic [WIDTH-1:0]  dvs_mag;

`ifdef SIGNED_DIV_EN
   logic neg_q_q, neg_q_d;
   logic neg_r_q, neg_r_d;
   logic ovf_pend_q, ovf_pend_d;
   logic ovf_q, ovf_d;

   assign dvd_mag = (signed_in && dividend_in[WIDTH-1]) ? -dividend_in : dividend_in;
   assign dvs_mag = (signed_in && divisor_in[WIDTH-1]) ? -divisor_in : divisor_in;
   assign overflow = ovf_q;
`else
   assign dvd_mag = dividend_in;
   assign dvs_mag = divisor_in;
`endif

   assign p_sh = {p_q[WIDTH-1:0], a_q[WIDTH-1]};

   trial_subtractor #(
      .W (WIDTH + 1)
   ) u_trial_subtractor (
      .a_i          (p_sh),
      .b_i          ({1'b0, dvs_q}),
      .diff_o       (diff),
      .borrow_out_o (borrow)
   );

   // A bit shifted out of P means the trial value certainly exceeds the divisor.
   assign take = ~borrow | p_q[WIDTH];

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      a_d     = a_q;
      dvs_d   = dvs_q;
      dvd_d   = dvd_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
      neg_q_d    = neg_q_q;
      neg_r_d    = neg_r_q;
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            // The done cycle is still part of the hand-off, so a start there is ignored.
            if (start_in && !done_q) begin
               dvd_d  = dividend_in;
               a_d    = dvd_mag;
               dvs_d  = dvs_mag;
               p_d    = '0;
               cnt_d  = CntW'(WIDTH);
               busy_d = 1'b1;
               dbz_d  = 1'b0;
`ifdef SIGNED_DIV_EN
               neg_q_d    = signed_in && (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
               neg_r_d    = signed_in && dividend_in[WIDTH-1];
               ovf_pend_d = signed_in && (dividend_in == {1'b1, {(WIDTH-1){1'b0}}})
                            && (divisor_in == '1);
               ovf_d      = 1'b0;
`endif
               state_d = (divisor_in == '0) ? StDone : StCalc;
            end
         end
         StCalc: begin
            p_d   = take ? diff : p_sh;
            a_d   = {a_q[WIDTH-2:0], take};
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
            if (dvs_q == '0) begin
               quo_d = '1;
               rem_d = dvd_q;
               dbz_d = 1'b1;
            end else begin
`ifdef SIGNED_DIV_EN
               quo_d = neg_q_q ? -a_q : a_q;
               rem_d = neg_r_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
               ovf_d = ovf_pend_q;
`else
               quo_d = a_q;
               rem_d = p_q[WIDTH-1:0];
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         p_q     <= '0;
         a_q     <= '0;
         dvs_q   <= '0;
         dvd_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         a_q     <= a_d;
         dvs_q   <= dvs_d;
         dvd_q   <= dvd_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
         neg_q_q    <= neg_q_d;
         neg_r_q    <= neg_r_d;
         ovf_pend_q <= ovf_pend_d;
         ovf_q      <= ovf_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_5bit.sv
// Self-checking bench for seq_divider_5bit: directed corners plus random operands vs. a model.
module tb_seq_divider_5bit;

   logic       clk;
   logic       reset;
   logic       start_in;
   logic [4:0] dividend_in;
   logic [4:0] divisor_in;
   logic       busy;
   logic       done;
   logic [4:0] quotient;
   logic [4:0] remainder;
   logic       div_by_zero;
   logic       sgn_mode;
`ifdef SIGNED_DIV_EN
   logic       signed_in;
   logic       overflow;
`endif

   int total;
   int bad;

   seq_divider_5bit dut (
      .clk         (clk),
      .reset       (reset),
`ifdef SIGNED_DIV_EN
      .signed_in   (signed_in),
      .overflow    (overflow),
`endif
      .start_in    (start_in),
      .dividend_in (dividend_in),
      .divisor_in  (divisor_in),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
      end
   endtask

   // Reference: plain integer division from the operand values.
   function automatic void model(input logic [4:0] dd, input logic [4:0] ds, input logic sgn,
                                 output logic [4:0] q, output logic [4:0] r, output logic ovf);
      int a;
      int b;
      ovf = 1'b0;
      if (ds == 5'd0) begin
         q = 5'h1f;
         r = dd;
      end else if (sgn) begin
         a   = $signed(dd);
         b   = $signed(ds);
         q   = 5'(a / b);
         r   = 5'(a % b);
         ovf = (dd == 5'h10) && (ds == 5'h1f);
      end else begin
         q = dd / ds;
         r = dd % ds;
      end
   endfunction

   task automatic do_div(input logic [4:0] dd, input logic [4:0] ds, input int inj);
      logic [4:0] eq;
      logic [4:0] er;
      logic       eovf;
      int         lat;
      logic       seen;
      model(dd, ds, sgn_mode, eq, er, eovf);
      @(negedge clk);
      start_in    = 1'b1;
      dividend_in = dd;
      divisor_in  = ds;
`ifdef SIGNED_DIV_EN
      signed_in   = sgn_mode;
`endif
      @(posedge clk);
      #1;
      start_in    = 1'b0;
      dividend_in = 5'($urandom);
      divisor_in  = 5'($urandom);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (i == inj) begin
            @(negedge clk);
            start_in    = 1'b1;
            dividend_in = 5'd10;
            divisor_in  = 5'd3;
         end
         @(posedge clk);
         #1;
         start_in = 1'b0;
         lat++;
         if (done) seen = 1'b1;
         else chk("busy_during_op", 32'(busy), 32'd1);
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), (ds == 5'd0) ? 32'd1 : 32'd6);
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("div_by_zero", 32'(div_by_zero), 32'(ds == 5'd0));
      chk("busy_at_done", 32'(busy), 32'd0);
`ifdef SIGNED_DIV_EN
      chk("overflow", 32'(overflow), 32'(eovf));
`endif
      @(posedge clk);
      #1;
      chk("done_pulse_one", 32'(done), 32'd0);
      chk("quotient_held", 32'(quotient), 32'(eq));
      chk("remainder_held", 32'(remainder), 32'(er));
      chk("dbz_held", 32'(div_by_zero), 32'(ds == 5'd0));
   endtask

   initial begin
      logic seen_done;
      total       = 0;
      bad         = 0;
      sgn_mode    = 1'b0;
      reset       = 1'b1;
      start_in    = 1'b0;
      dividend_in = 5'd0;
      divisor_in  = 5'd0;
`ifdef SIGNED_DIV_EN
      signed_in   = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      do_div(5'd23, 5'd5, -1);
      do_div(5'd17, 5'd0, -1);
      do_div(5'd31, 5'd1, -1);
      do_div(5'd4, 5'd9, -1);
      do_div(5'd0, 5'd7, -1);
      do_div(5'd31, 5'd31, -1);
      // Spurious start at cycle 2 must not disturb 30/7; 10/3 follows back-to-back.
      do_div(5'd30, 5'd7, 2);
      do_div(5'd10, 5'd3, -1);

      // Reset in the middle of 29/4.
      @(negedge clk);
      start_in    = 1'b1;
      dividend_in = 5'd29;
      divisor_in  = 5'd4;
      @(posedge clk);
      #1;
      start_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_quotient", 32'(quotient), 32'd0);
      chk("midrst_remainder", 32'(remainder), 32'd0);
      chk("midrst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      reset     = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      chk("midrst_no_done", 32'(seen_done), 32'd0);
      do_div(5'd29, 5'd4, -1);

      for (int i = 0; i < 40; i++) begin
         do_div(5'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), -1);
      end

`ifdef SIGNED_DIV_EN
      sgn_mode = 1'b1;
      do_div(5'b10011, 5'd4, -1);
      do_div(5'b10000, 5'b11111, -1);
      for (int i = 0; i < 20; i++) begin
         do_div(5'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), -1);
      end
      sgn_mode = 1'b0;
      do_div(5'd23, 5'd5, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
